regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (RegWrite/WriteAddr/WriteData) between two writeback sources.
  - ALU pipeline: fixed-timing, no backpressure.
  - Long-latency unit (load/mul): valid/ready handshake.
- Holds a 32-entry pending-write scoreboard for long-latency destinations and drives the ID-stage stall.
- Sits between the EX/MEM writeback paths and the register file in ID.
- A starvation guard periodically holds the ALU pipeline so the long-latency source always drains.

---
 rtl/regfile_wb_arbiter_if.sv | 51 +++++
 rtl/regfile_wb_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbitration bus between the EX/MEM writeback sources, the ID stage
// and the register file write port.
//   alu_*      : fixed-timing ALU result (no backpressure)
//   mem_*      : long-latency result with valid/ready handshake
//   alu_hold   : ALU pipeline must present alu_valid=0 while high
//   issue_*    : long-latency issue into the pending-write scoreboard
//   rs*/id_*   : ID-stage operand/destination usage; stall is the ID stall
//   RegWrite/WriteAddr/WriteData : register file write port
// Modports: slave = arbiter view, master = surrounding pipeline view.
`timescale 1ns/1ps
interface regfile_wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        alu_hold;
  logic        issue_valid;
  logic        issue_long;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1Addr;
  logic [4:0]  rs2Addr;
  logic        rs1_used;
  logic        rs2_used;
  logic [4:0]  id_rd;
  logic        id_wr;
  logic        stall;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready, alu_hold,
    input  issue_valid, issue_long, issue_rd,
    input  rs1Addr, rs2Addr, rs1_used, rs2_used, id_rd, id_wr,
    output stall, RegWrite, WriteAddr, WriteData
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready, alu_hold,
    output issue_valid, issue_long, issue_rd,
    output rs1Addr, rs2Addr, rs1_used, rs2_used, id_rd, id_wr,
    input  stall, RegWrite, WriteAddr, WriteData
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between the ALU pipeline and the
// long-latency unit, tracks pending long-latency destinations and drives the
// ID stall. A starvation guard holds the ALU for one cycle after the
// long-latency source has been blocked STARVE_LIMIT consecutive cycles.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : regfile_wb_arbiter_if.slave (sources, scoreboard, write port)
`timescale 1ns/1ps
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_wb_arbiter_if.slave     bus
);

  localparam logic [0:0] StNormal = 1'b0;
  localparam logic [0:0] StHold   = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      pending_q, pending_d;
  logic             reg_write_q, reg_write_d;
  logic [4:0]       write_addr_q, write_addr_d;
  logic [31:0]      write_data_q, write_data_d;

  logic        alu_grant;
  logic        mem_grant;
  logic        blocked;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] pending_eff;

  always_comb begin
    // The ALU is only honoured in NORMAL; in HOLD its valid is ignored.
    alu_grant = (state_q == StNormal) && bus.alu_valid;
    mem_grant = bus.mem_valid && !alu_grant;
    blocked   = (state_q == StNormal) && bus.mem_valid && !mem_grant;

    set_mask = '0;
    if (bus.issue_valid && bus.issue_long) set_mask = 32'd1 << bus.issue_rd;
    clr_mask = '0;
    if (mem_grant) clr_mask = 32'd1 << bus.mem_addr;

    // Set wins over a same-cycle clear of the same register.
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;

    // A clearing grant releases the stall in the same cycle; the register file
    // write-forward mux covers the one-cycle write latency.
    pending_eff = pending_q & ~clr_mask;

    wait_cnt_d = wait_cnt_q;
    if (mem_grant || state_q == StHold) begin
      wait_cnt_d = '0;
    end else if (blocked && wait_cnt_q != {CNT_W{1'b1}}) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    state_d = StNormal;
    if (state_q == StNormal && blocked && wait_cnt_q == CNT_W'(STARVE_LIMIT - 1)) begin
      state_d = StHold;
    end

    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (alu_grant) begin
      reg_write_d  = (bus.alu_addr != 5'd0);
      write_addr_d = bus.alu_addr;
      write_data_d = bus.alu_data;
    end else if (mem_grant) begin
      reg_write_d  = (bus.mem_addr != 5'd0);
      write_addr_d = bus.mem_addr;
      write_data_d = bus.mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StNormal;
      wait_cnt_q   <= '0;
      pending_q    <= '0;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      pending_q    <= pending_d;
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign bus.mem_ready = mem_grant;
  assign bus.alu_hold  = (state_q == StHold);
  assign bus.stall     = (bus.rs1_used && pending_eff[bus.rs1Addr]) ||
                         (bus.rs2_used && pending_eff[bus.rs2Addr]) ||
                         (bus.id_wr    && pending_eff[bus.id_rd]);
  assign bus.RegWrite  = reg_write_q;
  assign bus.WriteAddr = write_addr_q;
  assign bus.WriteData = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(
    .STARVE_LIMIT (4),
    .CNT_W        (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid   = 1'b0;
    bus.alu_addr    = 5'd0;
    bus.alu_data    = 32'd0;
    bus.mem_valid   = 1'b0;
    bus.mem_addr    = 5'd0;
    bus.mem_data    = 32'd0;
    bus.issue_valid = 1'b0;
    bus.issue_long  = 1'b0;
    bus.issue_rd    = 5'd0;
    bus.rs1Addr     = 5'd0;
    bus.rs2Addr     = 5'd0;
    bus.rs1_used    = 1'b0;
    bus.rs2_used    = 1'b0;
    bus.id_rd       = 5'd0;
    bus.id_wr       = 1'b0;
  endtask

  // ALU pipeline must never present a result while held.
  always @(negedge clk) begin
    if (!rst && bus.alu_hold) chk("alu_hold_protocol", {31'd0, bus.alu_valid}, 32'd0);
  end

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    chk("rst_waddr", {27'd0, bus.WriteAddr}, 32'd0);
    chk("rst_wdata", bus.WriteData, 32'd0);
    chk("rst_alu_hold", {31'd0, bus.alu_hold}, 32'd0);
    rst = 1'b0;
    tick();

    // ALU write, then idle hold, then write to x0
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    bus.alu_valid = 1'b0;
    chk("alu_regwrite", {31'd0, bus.RegWrite}, 32'd1);
    chk("alu_waddr", {27'd0, bus.WriteAddr}, 32'd5);
    chk("alu_wdata", bus.WriteData, 32'hDEADBEEF);
    tick();
    chk("idle_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    chk("idle_waddr_hold", {27'd0, bus.WriteAddr}, 32'd5);
    chk("idle_wdata_hold", bus.WriteData, 32'hDEADBEEF);
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 32'h11;
    tick();
    bus.alu_valid = 1'b0;
    chk("alu_x0_regwrite", {31'd0, bus.RegWrite}, 32'd0);

    // Collision: ALU first, then the long-latency result
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd4; bus.alu_data = 32'hA;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd7; bus.mem_data = 32'h1234;
    #1 chk("coll_mem_ready0", {31'd0, bus.mem_ready}, 32'd0);
    tick();
    chk("coll_alu_waddr", {27'd0, bus.WriteAddr}, 32'd4);
    chk("coll_alu_wdata", bus.WriteData, 32'hA);
    bus.alu_valid = 1'b0;
    #1 chk("coll_mem_ready1", {31'd0, bus.mem_ready}, 32'd1);
    tick();
    bus.mem_valid = 1'b0;
    chk("coll_mem_regwrite", {31'd0, bus.RegWrite}, 32'd1);
    chk("coll_mem_waddr", {27'd0, bus.WriteAddr}, 32'd7);
    chk("coll_mem_wdata", bus.WriteData, 32'h1234);
    tick();

    // Starvation: two rounds back to back show wait_cnt restarts from zero
    for (int r = 0; r < 2; r++) begin
      bus.mem_valid = 1'b1;
      bus.mem_addr  = (r == 0) ? 5'd8 : 5'd10;
      bus.mem_data  = 32'h5555 + r;
      for (int k = 0; k < 5; k++) begin
        bus.alu_valid = ~bus.alu_hold;
        bus.alu_addr  = 5'd1;
        bus.alu_data  = k;
        #1;
        if (k < 4) begin
          chk($sformatf("starve%0d_hold_c%0d", r, k), {31'd0, bus.alu_hold}, 32'd0);
          chk($sformatf("starve%0d_ready_c%0d", r, k), {31'd0, bus.mem_ready}, 32'd0);
        end else begin
          chk($sformatf("starve%0d_hold_c4", r), {31'd0, bus.alu_hold}, 32'd1);
          chk($sformatf("starve%0d_ready_c4", r), {31'd0, bus.mem_ready}, 32'd1);
        end
        tick();
      end
      bus.mem_valid = 1'b0;
      bus.alu_valid = 1'b1;
      chk($sformatf("starve%0d_hold_after", r), {31'd0, bus.alu_hold}, 32'd0);
      chk($sformatf("starve%0d_waddr", r), {27'd0, bus.WriteAddr}, (r == 0) ? 32'd8 : 32'd10);
      chk($sformatf("starve%0d_wdata", r), bus.WriteData, 32'h5555 + r);
      tick();
    end
    idle();
    tick();

    // Scoreboard: RAW on rs1/rs2, WAW on id_rd, release on grant
    bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd9;
    tick();
    idle();
    bus.rs1_used = 1'b1; bus.rs1Addr = 5'd9;
    #1 chk("sb_rs1_stall", {31'd0, bus.stall}, 32'd1);
    bus.rs1Addr = 5'd10;
    #1 chk("sb_rs1_other", {31'd0, bus.stall}, 32'd0);
    bus.rs1_used = 1'b0; bus.rs2_used = 1'b1; bus.rs2Addr = 5'd9;
    #1 chk("sb_rs2_stall", {31'd0, bus.stall}, 32'd1);
    bus.rs2_used = 1'b0; bus.id_wr = 1'b1; bus.id_rd = 5'd9;
    #1 chk("sb_waw_stall", {31'd0, bus.stall}, 32'd1);
    bus.id_wr = 1'b0;
    #1 chk("sb_no_use", {31'd0, bus.stall}, 32'd0);
    tick();
    bus.rs1_used = 1'b1; bus.rs1Addr = 5'd9;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd9; bus.mem_data = 32'h99;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd2; bus.alu_data = 32'h2;
    #1 chk("sb_blocked_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    #1 chk("sb_grant_release", {31'd0, bus.stall}, 32'd0);
    tick();
    bus.mem_valid = 1'b0;
    #1 chk("sb_cleared", {31'd0, bus.stall}, 32'd0);
    chk("sb_wr_x9", {27'd0, bus.WriteAddr}, 32'd9);
    chk("sb_wr_x9_data", bus.WriteData, 32'h99);
    idle();

    // Same-cycle set and clear of x3: set wins; issue to x0 is ignored
    bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd3;
    tick();
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd3; bus.mem_data = 32'h3;
    tick();
    idle();
    bus.rs1_used = 1'b1; bus.rs1Addr = 5'd3;
    #1 chk("setclr_pending3", {31'd0, bus.stall}, 32'd1);
    bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd0;
    tick();
    bus.issue_valid = 1'b0;
    bus.rs1Addr = 5'd0; bus.rs2_used = 1'b1; bus.rs2Addr = 5'd0;
    bus.id_wr = 1'b1; bus.id_rd = 5'd0;
    #1 chk("x0_no_stall", {31'd0, bus.stall}, 32'd0);
    bus.rs1Addr = 5'd3;
    #1 chk("x0_pending3_kept", {31'd0, bus.stall}, 32'd1);
    idle();
    tick();

    // Reset mid-traffic
    bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd12;
    tick();
    idle();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd6; bus.alu_data = 32'h66;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd13; bus.mem_data = 32'h1313;
    tick();
    bus.rs1_used = 1'b1; bus.rs1Addr = 5'd12;
    #1 chk("pre_rst_stall", {31'd0, bus.stall}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    chk("mid_rst_waddr", {27'd0, bus.WriteAddr}, 32'd0);
    chk("mid_rst_wdata", bus.WriteData, 32'd0);
    chk("mid_rst_alu_hold", {31'd0, bus.alu_hold}, 32'd0);
    chk("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    rst = 1'b0;
    bus.alu_valid = 1'b0;
    #1;
    chk("post_rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("post_rst_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
    tick();
    bus.mem_valid = 1'b0;
    chk("post_rst_reoffer_wr", {31'd0, bus.RegWrite}, 32'd1);
    chk("post_rst_reoffer_addr", {27'd0, bus.WriteAddr}, 32'd13);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
